logit_search_fixed: RTL and testbench

//   Inverse of the fixed-point PWL sigmoid: maps a QFRAC probability back to a raw score.

---
 rtl/logit_search_fixed.sv | 157 +++++++++++++++
 tb/tb_logit_search_fixed.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/logit_search_fixed.sv
// logit_search_fixed
//   Inverse of the fixed-point piecewise-linear sigmoid. Given a QFRAC
//   probability p, it scans integer scores x from -CLIP_X upward. It returns
//   the first x whose forward value f(x) reaches p, and scales that x by
//   2**SHIFT. The forward curve is not monotonic, so the scan must be
//   linear: a binary search could land on a later crossing.
//
// Ports
//   clk        clock, all state changes on posedge
//   rst        synchronous reset, active-high
//   in_valid   request valid
//   in_ready   block idle and able to accept a request
//   in_p       unsigned QFRAC probability (W bits)
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   out_z      signed score x <<< SHIFT (W+5 bits)
//   out_x      signed search result x (5 bits)
//   out_sat    in_p was above 1.0 and was clamped
module logit_search_fixed #(
   parameter int W      = 8,
   parameter int FRAC   = 6,
   parameter int SHIFT  = 6,
   parameter int CLIP_X = 8
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [W-1:0]   in_p,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [W+4:0]   out_z,
   output logic [4:0]     out_x,
   output logic           out_sat
);

   localparam int FW = W + FRAC + 3;
   localparam int ZW = W + 5;

   typedef logic signed [FW-1:0] fval_t;

   localparam fval_t F_ZERO = fval_t'(0);
   localparam fval_t F_ONE  = fval_t'(1 << FRAC);
   localparam fval_t F_CLIP = fval_t'(CLIP_X);
   localparam fval_t F_FOUR = fval_t'(4);
   localparam fval_t F_LO   = fval_t'(1 << (FRAC - 4));
   localparam fval_t F_MID  = fval_t'(1 << (FRAC - 1));
   localparam fval_t F_HI   = fval_t'(3 << (FRAC - 2));

   localparam logic [W-1:0]       P_ONE    = W'(1 << FRAC);
   localparam logic signed [4:0]  CAND_MIN = 5'(-CLIP_X);
   localparam logic signed [4:0]  CAND_MAX = 5'(CLIP_X);

   typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;

   // Clamp a forward value to the legal probability range [0, 1.0].
   function automatic fval_t sat_prob(input fval_t v);
      fval_t r;
      if (v < F_ZERO)
         r = F_ZERO;
      else if (v > F_ONE)
         r = F_ONE;
      else
         r = v;
      return r;
   endfunction

   // Forward PWL sigmoid. The first matching segment wins, so the outer
   // clip segments shadow the inner ones.
   function automatic fval_t fwd(input logic signed [4:0] x);
      fval_t xe;
      fval_t r;
      xe = fval_t'(x);
      if (xe <= -F_CLIP)
         r = F_ZERO;
      else if (xe >= F_CLIP)
         r = F_ONE;
      else if (xe <= -F_FOUR)
         r = F_LO + ((xe + F_FOUR) <<< (FRAC - 4));
      else if (xe <= F_FOUR)
         r = F_MID + (xe <<< (FRAC - 3));
      else
         r = F_HI + ((xe - F_FOUR) <<< (FRAC - 4));
      return sat_prob(r);
   endfunction

   state_t                 state;
   logic [W-1:0]           p;
   logic                   sat;
   logic signed [4:0]      cand;

   fval_t                  f_cand;
   logic                   hit;
   logic signed [ZW-1:0]   z_cand;

   // Search step: evaluate the current candidate.
   always_comb begin
      f_cand = fwd(cand);
      hit    = (f_cand >= fval_t'(p)) || (cand == CAND_MAX);
      z_cand = ZW'(cand) <<< SHIFT;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         out_z     <= '0;
         out_x     <= '0;
         out_sat   <= 1'b0;
         p         <= '0;
         sat       <= 1'b0;
         cand      <= CAND_MIN;
      end else begin
         case (state)
            // Accept: in_p is sampled only here.
            IDLE: begin
               if (in_ready && in_valid) begin
                  p        <= (in_p > P_ONE) ? P_ONE : in_p;
                  sat      <= (in_p > P_ONE);
                  cand     <= CAND_MIN;
                  in_ready <= 1'b0;
                  state    <= SEARCH;
               end else begin
                  // Also covers the cycle after a result handshake, so
                  // in_ready rises one cycle after leaving DONE.
                  in_ready <= 1'b1;
               end
            end
            // Search: one candidate per cycle, ascending. The top
            // candidate always hits, which bounds the scan.
            SEARCH: begin
               if (hit) begin
                  out_x     <= cand;
                  out_z     <= z_cand;
                  out_sat   <= sat;
                  out_valid <= 1'b1;
                  state     <= DONE;
               end else begin
                  cand <= cand + 5'sd1;
               end
            end
            // Result hold: outputs frozen until the consumer takes them.
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  state     <= IDLE;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_logit_search_fixed.sv
// tb_logit_search_fixed
//   Directed bench for logit_search_fixed with W=8, FRAC=6, SHIFT=6,
//   CLIP_X=8. Expected results come from the tabulated forward curve and a
//   first-hit scan over that table.
module tb_logit_search_fixed;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  in_p;
   logic        out_valid;
   logic        out_ready;
   logic [12:0] out_z;
   logic [4:0]  out_x;
   logic        out_sat;

   int checks = 0;
   int errors = 0;

   // f(x) for x = -8..8 with FRAC = 6
   int ftab [17] = '{0, 0, 0, 0, 4, 8, 16, 24, 32, 40, 48, 56, 64, 52, 56, 60, 64};

   always #5 clk = ~clk;

   logit_search_fixed #(.W(8), .FRAC(6), .SHIFT(6), .CLIP_X(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_z     (out_z),
      .out_x     (out_x),
      .out_sat   (out_sat)
   );

   task automatic check_val(input string tag, input int got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int ref_x(input int p);
      int pc;
      pc = (p > 64) ? 64 : p;
      for (int x = -8; x <= 8; x++)
         if (ftab[x + 8] >= pc) return x;
      return 8;
   endfunction

   // One complete transaction: wait for in_ready, present p, wait for the
   // result, optionally stall the consumer, then hand the result off.
   task automatic run_req(input int p, input int stall, input bit noise);
      int n;
      int lat;
      int ex;
      n = 0;
      while (!in_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check_val("in_ready_before_req", int'(in_ready), 1);
      ex       = ref_x(p);
      in_p     = p[7:0];
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_p     = 8'($urandom);
      lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 40) begin
         if (noise) begin
            in_valid = 1'($urandom);
            in_p     = 8'($urandom);
         end
         @(negedge clk);
         lat++;
      end
      in_valid = 1'b0;
      check_val("latency", lat, ex + 9);
      for (int i = 0; i < stall; i++) begin
         in_p = 8'($urandom);
         @(negedge clk);
      end
      check_val("out_valid_held", int'(out_valid), 1);
      check_val("in_ready_busy", int'(in_ready), 0);
      check_val("out_x", int'($signed(out_x)), ex);
      check_val("out_z", int'($signed(out_z)), ex * 64);
      check_val("out_sat", int'(out_sat), (p > 64) ? 1 : 0);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_val("out_valid_drop", int'(out_valid), 0);
      check_val("in_ready_gap", int'(in_ready), 0);
      @(posedge clk);
      #1;
      check_val("in_ready_rise", int'(in_ready), 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_p      = 8'd0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_val("rst_in_ready", int'(in_ready), 1);
      check_val("rst_out_valid", int'(out_valid), 0);
      check_val("rst_out_z", int'(out_z), 0);
      check_val("rst_out_x", int'(out_x), 0);
      check_val("rst_out_sat", int'(out_sat), 0);
      rst = 1'b0;
      @(negedge clk);

      // Extremes and mid-curve points
      run_req(0, 0, 1'b0);
      run_req(32, 0, 1'b0);
      run_req(50, 0, 1'b0);
      run_req(64, 0, 1'b0);
      run_req(200, 0, 1'b0);

      // Reset in the middle of a search, with non-zero outputs left from
      // the previous result.
      @(negedge clk);
      in_p     = 8'd64;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check_val("midrst_in_ready", int'(in_ready), 1);
      check_val("midrst_out_valid", int'(out_valid), 0);
      check_val("midrst_out_z", int'(out_z), 0);
      check_val("midrst_out_x", int'(out_x), 0);
      check_val("midrst_out_sat", int'(out_sat), 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_val("midrst_out_valid2", int'(out_valid), 0);
      run_req(32, 0, 1'b0);

      // Long consumer stall
      run_req(50, 10, 1'b0);

      // Sweep with random stalls and busy-time in_valid noise
      for (int p = 0; p < 256; p++)
         run_req(p, int'($urandom_range(0, 3)), 1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
